// File: rtl/sbox_inv_affine_stage_if.sv
// Handshake bundle for the masked inverse-affine stage: two input shares plus
// a refresh byte on the upstream side, and two output shares on the downstream side.
interface sbox_inv_affine_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] r;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [1:0] occupancy;

    modport master (
        output in_valid, in0, in1, r, out_ready,
        input  in_ready, out_valid, out0, out1, occupancy
    );

    modport slave (
        input  in_valid, in0, in1, r, out_ready,
        output in_ready, out_valid, out0, out1, occupancy
    );
endinterface

// File: rtl/sbox_inv_affine_stage.sv
// Two-share masked AES inverse-affine stage with a FIFO-ordered valid/ready buffer.
// Optional macro SHARE_REFRESH_EN: XOR the fresh byte r into both shares on accept.
module sbox_inv_affine_stage #(
    parameter int DEPTH       = 2,
    parameter int CONST_SHARE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sbox_inv_affine_stage_if.slave bus
);

    localparam logic [1:0] DEPTH_L = 2'(DEPTH);

    logic [1:0] occ_q;
    logic [1:0] occ_d;
    logic       push;
    logic       pop;
    logic       load_head;
    logic       head_from_skid;
    logic       load_skid;

    assign bus.in_ready  = (occ_q < DEPTH_L) || bus.out_ready;
    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.occupancy = occ_q;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Buffer is a head register plus one skid register; enables depend only on handshakes.
    always_comb begin
        occ_d          = occ_q;
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    load_head = 1'b1;
                    occ_d     = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (pop) begin
                    occ_d = 2'd0;
                end else if (push) begin
                    load_skid = 1'b1;
                    occ_d     = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    load_head      = 1'b1;
                    head_from_skid = 1'b1;
                    if (push) begin
                        load_skid = 1'b1;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Each share has its own map and its own flops; nothing here mixes share 0 with share 1.
    for (genvar gi = 0; gi < 2; gi++) begin : share_g
        localparam logic [7:0] INJECT = (gi == CONST_SHARE) ? 8'h05 : 8'h00;

        logic [7:0] y;
        logic [7:0] aff;
        logic [7:0] wr;
        logic [7:0] head_q;
        logic [7:0] head_d;
        logic [7:0] skid_q;
        logic [7:0] skid_d;

        assign y = (gi == 0) ? bus.in0 : bus.in1;

        for (genvar bi = 0; bi < 8; bi++) begin : bit_g
            assign aff[bi] = y[(bi + 2) % 8] ^ y[(bi + 5) % 8] ^ y[(bi + 7) % 8] ^ INJECT[bi];
        end

`ifdef SHARE_REFRESH_EN
        assign wr = aff ^ bus.r;
`else
        assign wr = aff;
`endif

        always_comb begin
            head_d = head_q;
            skid_d = skid_q;
            if (load_head) begin
                head_d = head_from_skid ? skid_q : wr;
            end
            if (load_skid) begin
                skid_d = wr;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                head_q <= 8'h00;
                skid_q <= 8'h00;
            end else begin
                head_q <= head_d;
                skid_q <= skid_d;
            end
        end
    end

    assign bus.out0 = share_g[0].head_q;
    assign bus.out1 = share_g[1].head_q;

endmodule

// File: tb/tb_sbox_inv_affine_stage.sv
// Self-checking bench for sbox_inv_affine_stage: directed scenarios plus a randomized
// sweep against a model built from the inverse of the forward AES affine map.
module tb_sbox_inv_affine_stage;

    localparam int DEPTH       = 2;
    localparam int CONST_SHARE = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sbox_inv_affine_stage_if bus ();

    sbox_inv_affine_stage #(
        .DEPTH       (DEPTH),
        .CONST_SHARE (CONST_SHARE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] inv_tab [256];

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] w;
        w = {b, b} << n;
        return w[15:8];
    endfunction

    // Invert the forward affine map by enumeration instead of using its closed form.
    task automatic build_table;
        logic [7:0] b;
        logic [7:0] f;
        for (int x = 0; x < 256; x++) begin
            b = 8'(x);
            f = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            inv_tab[f] = b;
        end
    endtask

    function automatic logic [7:0] refresh_of(input logic [7:0] rr);
`ifdef SHARE_REFRESH_EN
        return rr;
`else
        return 8'h00 & rr;
`endif
    endfunction

    function automatic logic [7:0] exp_share(input int s, input logic [7:0] y, input logic [7:0] rr);
        if (s == CONST_SHARE) return inv_tab[y] ^ refresh_of(rr);
        return inv_tab[y] ^ inv_tab[8'h00] ^ refresh_of(rr);
    endfunction

    // Stimulus only: present one byte for one edge, then drop in_valid.
    task automatic push_one(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] rr);
        bus.in_valid = 1'b1;
        bus.in0      = a0;
        bus.in1      = a1;
        bus.r        = rr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in0       = 8'h00;
        bus.in1       = 8'h00;
        bus.r         = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", bus.occupancy); end
        checks++;
        if (bus.out0 !== 8'h00 || bus.out1 !== 8'h00) begin
            errors++; $display("FAIL reset_outputs: got %h/%h expected 00/00", bus.out0, bus.out1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_known_answer;
        logic [7:0] rr;
        logic [7:0] held0;
        logic [7:0] held1;
        bus.out_ready = 1'b1;
        rr = 8'($urandom);
        push_one(8'h63, 8'h00, rr);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL kat1_valid: got %b expected 1", bus.out_valid); end
        checks++;
        if ((bus.out0 ^ bus.out1) !== 8'h00) begin errors++; $display("FAIL kat1_unmasked: got %h expected 00", bus.out0 ^ bus.out1); end
        checks++;
        if (bus.out0 !== exp_share(0, 8'h63, rr) || bus.out1 !== exp_share(1, 8'h00, rr)) begin
            errors++; $display("FAIL kat1_shares: got %h/%h expected %h/%h", bus.out0, bus.out1,
                               exp_share(0, 8'h63, rr), exp_share(1, 8'h00, rr));
        end
        rr = 8'($urandom);
        push_one(8'h3C, 8'h40, rr);
        checks++;
        if ((bus.out0 ^ bus.out1) !== 8'h01 || bus.occupancy !== 2'd1) begin
            errors++; $display("FAIL kat2_unmasked: got %h occ %0d expected 01 occ 1", bus.out0 ^ bus.out1, bus.occupancy);
        end
        held0 = exp_share(0, 8'h3C, rr);
        held1 = exp_share(1, 8'h40, rr);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL kat_drain_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.out0 !== held0 || bus.out1 !== held1) begin
            errors++; $display("FAIL empty_hold: got %h/%h expected %h/%h", bus.out0, bus.out1, held0, held1);
        end
    endtask

    task automatic test_share_wise;
        logic [7:0] rr;
        rr = 8'($urandom);
        bus.out_ready = 1'b1;
        push_one(8'h00, 8'h63, rr);
        checks++;
        if (bus.out0 !== exp_share(0, 8'h00, rr) || bus.out1 !== exp_share(1, 8'h63, rr)) begin
            errors++; $display("FAIL share_wise: got %h/%h expected %h/%h", bus.out0, bus.out1,
                               exp_share(0, 8'h00, rr), exp_share(1, 8'h63, rr));
        end
        checks++;
        if ((bus.out0 ^ bus.out1) !== 8'h00) begin errors++; $display("FAIL share_wise_unmasked: got %h expected 00", bus.out0 ^ bus.out1); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        logic [7:0] m;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        m = 8'($urandom); bus.in0 = 8'h63 ^ m; bus.in1 = m;
        @(posedge clk); #1;
        checks++;
        if (bus.occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ1: got %0d expected 1", bus.occupancy); end
        m = 8'($urandom); bus.in0 = 8'h7C ^ m; bus.in1 = m;
        @(posedge clk); #1;
        checks++;
        if (bus.occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ2: got %0d expected 2", bus.occupancy); end
        m = 8'($urandom); bus.in0 = 8'h77 ^ m; bus.in1 = m;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", bus.in_ready); end
        @(posedge clk); #1;
        checks++;
        if (bus.occupancy !== 2'd2 || (bus.out0 ^ bus.out1) !== inv_tab[8'h63]) begin
            errors++; $display("FAIL bp_stall: got occ %0d head %h expected occ 2 head %h",
                               bus.occupancy, bus.out0 ^ bus.out1, inv_tab[8'h63]);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.occupancy !== 2'd2 || (bus.out0 ^ bus.out1) !== inv_tab[8'h7C]) begin
            errors++; $display("FAIL bp_pop1: got occ %0d head %h expected occ 2 head %h",
                               bus.occupancy, bus.out0 ^ bus.out1, inv_tab[8'h7C]);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.occupancy !== 2'd1 || (bus.out0 ^ bus.out1) !== inv_tab[8'h77]) begin
            errors++; $display("FAIL bp_pop2: got occ %0d head %h expected occ 1 head %h",
                               bus.occupancy, bus.out0 ^ bus.out1, inv_tab[8'h77]);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty: got %0d expected 0", bus.occupancy); end
    endtask

    task automatic test_refresh;
        bus.out_ready = 1'b1;
        push_one(8'h7C, 8'h00, 8'hA5);
        checks++;
        if ((bus.out0 ^ bus.out1) !== 8'h01) begin errors++; $display("FAIL refresh_unmasked: got %h expected 01", bus.out0 ^ bus.out1); end
        checks++;
        if (bus.out1 !== exp_share(1, 8'h00, 8'hA5)) begin
            errors++; $display("FAIL refresh_share1: got %h expected %h", bus.out1, exp_share(1, 8'h00, 8'hA5));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stream;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in0 = 8'($urandom); bus.in1 = 8'($urandom); bus.r = 8'($urandom);
        @(posedge clk); #1;
        bus.in0 = 8'($urandom); bus.in1 = 8'($urandom);
        @(posedge clk); #1;
        checks++;
        if (bus.occupancy !== 2'd2) begin errors++; $display("FAIL mid_fill: got %0d expected 2", bus.occupancy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0 || bus.out0 !== 8'h00 || bus.out1 !== 8'h00) begin
            errors++; $display("FAIL mid_reset: got v%b occ %0d %h/%h expected v0 occ 0 00/00",
                               bus.out_valid, bus.occupancy, bus.out0, bus.out1);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out0 !== 8'h00 || bus.out1 !== 8'h00) begin
            errors++; $display("FAIL mid_release: got rdy %b %h/%h expected rdy 1 00/00", bus.in_ready, bus.out0, bus.out1);
        end
    endtask

    task automatic test_random_sweep;
        logic [7:0] q0 [$];
        logic [7:0] q1 [$];
        logic [7:0] qy [$];
        logic [7:0] last0;
        logic [7:0] last1;
        logic [7:0] y;
        logic [7:0] m;
        logic       exp_rdy;
        int         accepted;
        int         cyc;
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        last0 = 8'h00; last1 = 8'h00;
        accepted = 0; cyc = 0;
        while ((accepted < 10000 || q0.size() > 0) && cyc < 60000) begin
            checks++;
            if (bus.occupancy !== 2'(q0.size()) || bus.out_valid !== (q0.size() > 0)) begin
                errors++; $display("FAIL sweep_state: got occ %0d v%b expected occ %0d", bus.occupancy, bus.out_valid, q0.size());
            end
            if (q0.size() > 0) begin
                last0 = q0[0];
                last1 = q1[0];
            end
            checks++;
            if (bus.out0 !== last0 || bus.out1 !== last1) begin
                errors++; $display("FAIL sweep_shares: got %h/%h expected %h/%h", bus.out0, bus.out1, last0, last1);
            end
            y = 8'($urandom); m = 8'($urandom);
            bus.in_valid  = (accepted < 10000) && ($urandom_range(0, 3) != 0);
            bus.in0       = y ^ m;
            bus.in1       = m;
            bus.r         = 8'($urandom);
            bus.out_ready = (accepted >= 10000) || ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (q0.size() < DEPTH) || bus.out_ready;
            checks++;
            if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL sweep_in_ready: got %b expected %b", bus.in_ready, exp_rdy); end
            if (q0.size() > 0 && bus.out_ready) begin
                checks++;
                if ((bus.out0 ^ bus.out1) !== qy[0]) begin
                    errors++; $display("FAIL sweep_unmask: got %h expected %h", bus.out0 ^ bus.out1, qy[0]);
                end
                void'(q0.pop_front()); void'(q1.pop_front()); void'(qy.pop_front());
            end
            if (bus.in_valid && exp_rdy) begin
                q0.push_back(exp_share(0, bus.in0, bus.r));
                q1.push_back(exp_share(1, bus.in1, bus.r));
                qy.push_back(inv_tab[y]);
                accepted++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (cyc >= 60000) begin errors++; $display("FAIL sweep_timeout: got %0d accepted, %0d pending expected 10000, 0", accepted, q0.size()); end
    endtask

    initial begin
        build_table();
        test_reset();
        test_known_answer();
        test_share_wise();
        test_backpressure();
        test_refresh();
        test_reset_mid_stream();
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
